// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder datapath.
// Used by serial_sum_collector and its frame counter.
package serial_adder_pkg;

    localparam int SA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } sc_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/serial_sum_collector_if.sv
// Bit-stream input and parallel result handshake of serial_sum_collector.
// Optional result_parity signal exists only when SERIAL_COLLECT_PARITY_EN is defined.
interface serial_sum_collector_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
);
    logic             bit_valid;
    logic             sum_bit;
    logic             carry_bit;
    logic             abort;
    logic             res_ready;
    logic             clr_overrun;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             res_valid;
    logic             busy;
    logic             overrun;
`ifdef SERIAL_COLLECT_PARITY_EN
    logic             result_parity;

    modport master (
        output bit_valid, sum_bit, carry_bit, abort, res_ready, clr_overrun,
        input  result, carry_out, res_valid, busy, overrun, result_parity
    );
    modport slave (
        input  bit_valid, sum_bit, carry_bit, abort, res_ready, clr_overrun,
        output result, carry_out, res_valid, busy, overrun, result_parity
    );
`else
    modport master (
        output bit_valid, sum_bit, carry_bit, abort, res_ready, clr_overrun,
        input  result, carry_out, res_valid, busy, overrun
    );
    modport slave (
        input  bit_valid, sum_bit, carry_bit, abort, res_ready, clr_overrun,
        output result, carry_out, res_valid, busy, overrun
    );
`endif
endinterface

// File: rtl/sc_bit_counter.sv
// Frame bit counter: clear (optionally loading the current bit as bit 0), enable,
// and a terminal-count flag that fires on the enable that brings the count to WIDTH.
module sc_bit_counter
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count accepted bits; a clear together with an enable starts a new frame at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= i_en ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = i_en & ~i_clr & (r_cnt == LAST_IDX);

endmodule

// File: rtl/serial_sum_collector.sv
// Collects an LSB-first serial sum plus final carry into a WIDTH-bit word on a valid/ready port.
// Optional feature macro: SERIAL_COLLECT_PARITY_EN adds result_parity.
module serial_sum_collector
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_sum_collector_if.slave bus
);
    sc_state_e        r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_carry;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    logic w_idle, w_collect, w_hold;
    logic w_abort, w_hs, w_start, w_accept, w_ovr_set, w_tc;

    assign w_idle    = (r_state == IDLE);
    assign w_collect = (r_state == COLLECT);
    assign w_hold    = (r_state == HOLD);
    assign w_abort   = w_collect & bus.abort;
    assign w_hs      = w_hold & bus.res_ready;
    // A frame starts in IDLE or in the same cycle a held result is taken.
    assign w_start   = bus.bit_valid & (w_idle | w_hs);
    assign w_accept  = w_start | (w_collect & bus.bit_valid & ~bus.abort);
    assign w_ovr_set = w_hold & ~bus.res_ready & bus.bit_valid;

    sc_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_clr(w_start | w_abort | w_hs),
        .i_en (w_accept),
        .o_tc (w_tc)
    );

    // Frame FSM with shift register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= {WIDTH{1'b0}};
            r_carry   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= {bus.sum_bit, r_shift[WIDTH-1:1]};
            end else begin
                r_shift <= r_shift;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end

            case (r_state)
                IDLE: begin
                    if (bus.bit_valid) begin
                        r_state <= COLLECT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_valid <= 1'b0;
                end
                COLLECT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else if (w_tc) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_carry <= bus.carry_bit;
                    end else begin
                        r_state <= COLLECT;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        if (bus.bit_valid) begin
                            r_state <= COLLECT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result    = r_shift;
    assign bus.carry_out = r_carry;
    assign bus.res_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

`ifdef SERIAL_COLLECT_PARITY_EN
    logic r_parity;

    // Serial even-parity of the current frame, restarted by the frame's first bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_start) begin
            r_parity <= bus.sum_bit;
        end else if (w_accept) begin
            r_parity <= parity_step(r_parity, bus.sum_bit);
        end else begin
            r_parity <= r_parity;
        end
    end

    assign bus.result_parity = r_parity;
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// Scoreboard bench for serial_sum_collector: frames are queued as words when issued,
// a forked monitor pops and compares on every completed handshake.
module tb_serial_sum_collector;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_sum_collector_if #(.WIDTH(W)) bus();

    serial_sum_collector #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 1;
    logic [W-1:0] exp_res_q[$];
    logic         exp_c_q[$];
`ifdef SERIAL_COLLECT_PARITY_EN
    logic         exp_p_q[$];
`endif

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready();
        if (ready_mode == 0)      bus.res_ready = 1'b0;
        else if (ready_mode == 1) bus.res_ready = 1'b1;
        else                      bus.res_ready = (($urandom % 4) != 0);
    endtask

    // Present one bit; never offer a bit while a result is held without ready.
    task automatic drive_bit(input logic b, input logic c);
        int guard;
        guard = 0;
        set_ready();
        while (bus.res_valid && !bus.res_ready && guard < 200) begin
            bus.bit_valid = 1'b0;
            tick();
            set_ready();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_bound: waited %0d cycles for res_ready", guard);
        end
        bus.bit_valid = 1'b1;
        bus.sum_bit   = b;
        bus.carry_bit = c;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] v, input logic c);
        exp_res_q.push_back(v);
        exp_c_q.push_back(c);
`ifdef SERIAL_COLLECT_PARITY_EN
        exp_p_q.push_back(^v);
`endif
    endtask

    task automatic send_frame(input logic [W-1:0] v, input logic c, input bit bubbles);
        push_exp(v, c);
        for (int i = 0; i < W; i++) begin
            if (bubbles && ($urandom % 4) == 0) begin
                bus.bit_valid = 1'b0;
                set_ready();
                tick();
            end
            drive_bit(v[i], (i == W - 1) ? c : 1'($urandom % 2));
        end
    endtask

    task automatic monitor();
        logic [W-1:0] held_r;
        logic         held_c;
        bit           holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || !bus.res_valid) begin
                holding = 1'b0;
            end else begin
                if (holding) begin
                    chk("hold_result_stable", bus.result, held_r);
                    chk1("hold_carry_stable", bus.carry_out, held_c);
                end
                if (bus.res_ready) begin
                    if (exp_res_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %h with empty scoreboard", bus.result);
                    end else begin
                        chk("result", bus.result, exp_res_q.pop_front());
                        chk1("carry_out", bus.carry_out, exp_c_q.pop_front());
`ifdef SERIAL_COLLECT_PARITY_EN
                        chk1("result_parity", bus.result_parity, exp_p_q.pop_front());
`endif
                    end
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held_r  = bus.result;
                    held_c  = bus.carry_out;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] pair;
        int g;
        bus.bit_valid   = 1'b0;
        bus.sum_bit     = 1'b0;
        bus.carry_bit   = 1'b0;
        bus.abort       = 1'b0;
        bus.res_ready   = 1'b1;
        bus.clr_overrun = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("rst_result", bus.result, '0);
        chk1("rst_carry", bus.carry_out, 1'b0);
        chk1("rst_valid", bus.res_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b1;
        tick();

        // DEADBEEF: valid one cycle after the last bit, single-cycle pulse
        ready_mode = 1;
        send_frame(32'hDEADBEEF, 1'b1, 1'b0);
        chk1("lat_valid", bus.res_valid, 1'b1);
        chk1("lat_busy", bus.busy, 1'b0);
        chk1("lat_carry", bus.carry_out, 1'b1);
        chk1("lat_overrun", bus.overrun, 1'b0);
        tick();
        chk1("pulse_valid_low", bus.res_valid, 1'b0);

        // Overrun while holding, clear vs set priority
        ready_mode = 0;
        send_frame(32'h00000005, 1'b0, 1'b0);
        chk1("ovr_hold_valid", bus.res_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.bit_valid = 1'b1;
            bus.sum_bit   = 1'($urandom % 2);
            tick();
            chk("ovr_result_kept", bus.result, 32'h00000005);
            chk1("ovr_set", bus.overrun, 1'b1);
        end
        bus.clr_overrun = 1'b1;
        tick();
        chk1("ovr_set_wins", bus.overrun, 1'b1);
        bus.bit_valid = 1'b0;
        tick();
        chk1("ovr_cleared", bus.overrun, 1'b0);
        bus.clr_overrun = 1'b0;
        ready_mode = 1;
        bus.res_ready = 1'b1;
        tick();
        chk1("ovr_released", bus.res_valid, 1'b0);

        // Back-to-back frames, first bit of frame 2 accepted during HOLD
        pair = {32'h9ABCDEF0, 32'h12345678};
        push_exp(32'h12345678, 1'b0);
        push_exp(32'h9ABCDEF0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            drive_bit(pair[i], (i == 31) ? 1'b0 : ((i == 63) ? 1'b1 : 1'($urandom % 2)));
            if (i == 31) chk1("b2b_valid1", bus.res_valid, 1'b1);
            if (i == 32) begin
                chk1("b2b_no_bubble_busy", bus.busy, 1'b1);
                chk1("b2b_valid_drop", bus.res_valid, 1'b0);
            end
            if (i == 63) chk1("b2b_valid2", bus.res_valid, 1'b1);
        end
        tick();

        // Abort a partial frame, then a full frame
        for (int i = 0; i < 10; i++) drive_bit(1'($urandom % 2), 1'b0);
        chk1("pre_abort_busy", bus.busy, 1'b1);
        bus.abort     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.sum_bit   = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.bit_valid = 1'b0;
        chk1("abort_busy", bus.busy, 1'b0);
        push_exp(32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < W; i++) begin
            drive_bit(1'b1, (i == W - 1) ? 1'b0 : 1'($urandom % 2));
            if (i == 0) chk1("after_abort_busy", bus.busy, 1'b1);
        end
        tick();

        // Reset in the middle of a frame
        for (int i = 0; i < 20; i++) drive_bit(1'b1, 1'b0);
        bus.bit_valid = 1'b1;
        rst = 1'b0;
        tick();
        chk("mid_rst_result", bus.result, '0);
        chk1("mid_rst_carry", bus.carry_out, 1'b0);
        chk1("mid_rst_valid", bus.res_valid, 1'b0);
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_overrun", bus.overrun, 1'b0);
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        tick();
        send_frame(32'h80000001, 1'b1, 1'b0);
        tick();

`ifdef SERIAL_COLLECT_PARITY_EN
        send_frame(32'h00000007, 1'b0, 1'b0);
        chk1("parity_7", bus.result_parity, 1'b1);
        tick();
        send_frame(32'h00000003, 1'b1, 1'b0);
        chk1("parity_3", bus.result_parity, 1'b0);
        tick();
`endif

        // Random frames with bubbles, random back-pressure and occasional aborts
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            if (($urandom % 5) == 0) begin
                int k;
                k = $urandom_range(1, W - 1);
                for (int i = 0; i < k; i++) drive_bit(1'($urandom % 2), 1'($urandom % 2));
                bus.abort     = 1'b1;
                bus.bit_valid = 1'($urandom % 2);
                bus.sum_bit   = 1'($urandom % 2);
                set_ready();
                tick();
                bus.abort     = 1'b0;
                bus.bit_valid = 1'b0;
                chk1("rand_abort_busy", bus.busy, 1'b0);
            end else begin
                send_frame($urandom, 1'($urandom % 2), 1'b1);
            end
        end

        ready_mode = 1;
        bus.res_ready = 1'b1;
        bus.bit_valid = 1'b0;
        g = 0;
        while (exp_res_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        tick();
        chk("queue_drained", W'(exp_res_q.size()), '0);
        chk1("final_valid", bus.res_valid, 1'b0);
        chk1("final_overrun", bus.overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
